// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, ALU codes,
// opcode/funct constants and datapath mux select codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEX,
        S_RTWB,
        S_BREX,
        S_IMMEX,
        S_IMMWB,
        S_JMP,
        S_JAL,
        S_JR,
        S_HALT
    } state_e;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write data select
    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Wait counter width; covers the largest legal TIMEOUT of 255
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction/status inputs and datapath control outputs of the controller.
interface mc_controller_if #(
    parameter int unsigned ALUW = 4
);
    logic [5:0]      op;
    logic [5:0]      funct;
    logic            zero;
    logic            mem_ready;

    logic            mem_req;
    logic            memwrite;
    logic            iord;
    logic            irwrite;
    logic            regwrite;
    logic            signext;
    logic            shiftl16;
    logic            alusrca;
    logic            pcen;
    logic [1:0]      regdst;
    logic [1:0]      wdsel;
    logic [1:0]      pcsrc;
    logic [1:0]      alusrcb;
    logic [ALUW-1:0] alucontrol;
    logic            retire;
    logic            bus_err;
    logic            illegal;

    modport slave (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, regwrite, signext, shiftl16,
               alusrca, pcen, regdst, wdsel, pcsrc, alusrcb, alucontrol,
               retire, bus_err, illegal
    );

    modport master (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, regwrite, signext, shiftl16,
               alusrca, pcen, regdst, wdsel, pcsrc, alusrcb, alucontrol,
               retire, bus_err, illegal
    );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: picks the ALU operation for the current controller state and
// flags R-type funct codes that have no ALU mapping.
module mc_aludec
    import mips_pkg::*;
#(
    parameter int unsigned ALUW = 4
) (
    input  state_e          state_i,
    input  logic [5:0]      op_i,
    input  logic [5:0]      funct_i,
    output logic [ALUW-1:0] alucontrol_o,
    output logic            funct_bad_o
);

    logic [3:0] rcode;
    logic [3:0] code;

    // R-type funct to ALU operation; unmapped functs raise funct_bad_o
    always_comb begin
        rcode       = ALU_AND;
        funct_bad_o = 1'b0;
        case (funct_i)
            F_ADD, F_ADDU: rcode = ALU_ADD;
            F_SUB, F_SUBU: rcode = ALU_SUB;
            F_AND:         rcode = ALU_AND;
            F_OR, F_SLL:   rcode = ALU_OR;
            F_SLT:         rcode = ALU_SLT;
            F_SLTU:        rcode = ALU_SLTU;
            default:       funct_bad_o = 1'b1;
        endcase
    end

    // Per-state ALU operation; states that do not use the ALU drive 0
    always_comb begin
        code = ALU_AND;
        case (state_i)
            S_FETCH, S_DECODE, S_MEMADR: code = ALU_ADD;
            S_BREX:                      code = ALU_SUB;
            S_RTEX:                      code = funct_bad_o ? ALU_AND : rcode;
            S_IMMEX:                     code = (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
            default:                     code = ALU_AND;
        endcase
        alucontrol_o = ALUW'(code);
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute,
// a per-access memory wait counter with timeout, and sticky error flags.
module mc_controller
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ALUW    = 4
) (
    input logic            clk,
    input logic            reset,
    mc_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             illegal_q, illegal_d;
    logic             pcwrite, beq, bne;
    logic             funct_bad;
    logic             wait_expired;
    logic [ALUW-1:0]  alucontrol;

    mc_aludec #(.ALUW(ALUW)) u_aludec (
        .state_i      (state_q),
        .op_i         (bus.op),
        .funct_i      (bus.funct),
        .alucontrol_o (alucontrol),
        .funct_bad_o  (funct_bad)
    );

    assign bus.alucontrol = alucontrol;
    assign bus.bus_err    = bus_err_q;
    assign bus.illegal    = illegal_q;
    assign wait_expired   = (cnt_q == CNT_LAST);

    // State, wait counter and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore control outputs
    always_comb begin
        state_d      = state_q;
        bus_err_d    = bus_err_q;
        illegal_d    = illegal_q;
        pcwrite      = 1'b0;
        beq          = 1'b0;
        bne          = 1'b0;
        bus.mem_req  = 1'b0;
        bus.memwrite = 1'b0;
        bus.iord     = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regwrite = 1'b0;
        bus.signext  = 1'b0;
        bus.shiftl16 = 1'b0;
        bus.alusrca  = 1'b0;
        bus.regdst   = '0;
        bus.wdsel    = '0;
        bus.pcsrc    = '0;
        bus.alusrcb  = '0;
        bus.retire   = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                bus.pcsrc   = PC_ALU;
                if (bus.mem_ready) begin
                    bus.irwrite = 1'b1;
                    pcwrite     = 1'b1;
                    state_d     = S_DECODE;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_IMMSH;
                case (bus.op)
                    OP_LW, OP_SW:                        state_d = S_MEMADR;
                    OP_RTYPE:                            state_d = (bus.funct == F_JR) ? S_JR : S_RTEX;
                    OP_BEQ, OP_BNE:                      state_d = S_BREX;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:   state_d = S_IMMEX;
                    OP_J:                                state_d = S_JMP;
                    OP_JAL:                              state_d = S_JAL;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                bus.signext = 1'b1;
                state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = REGDST_RT;
                bus.wdsel    = WD_MDR;
                bus.retire   = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    state_d    = S_FETCH;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_RTEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_RT;
                if (funct_bad) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_RTWB;
                end
            end
            S_RTWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = REGDST_RD;
                bus.wdsel    = WD_ALUOUT;
                bus.retire   = 1'b1;
                state_d      = S_FETCH;
            end
            S_BREX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_RT;
                bus.pcsrc   = PC_ALUOUT;
                beq         = (bus.op == OP_BEQ);
                bne         = (bus.op == OP_BNE);
                bus.retire  = 1'b1;
                state_d     = S_FETCH;
            end
            S_IMMEX: begin
                bus.alusrca  = 1'b1;
                bus.alusrcb  = SRCB_IMM;
                bus.signext  = (bus.op == OP_ADDI) || (bus.op == OP_ADDIU);
                bus.shiftl16 = (bus.op == OP_LUI);
                state_d      = S_IMMWB;
            end
            S_IMMWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = REGDST_RT;
                bus.wdsel    = WD_ALUOUT;
                bus.retire   = 1'b1;
                state_d      = S_FETCH;
            end
            S_JMP: begin
                pcwrite    = 1'b1;
                bus.pcsrc  = PC_JUMP;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                pcwrite      = 1'b1;
                bus.pcsrc    = PC_JUMP;
                bus.regwrite = 1'b1;
                bus.regdst   = REGDST_RA;
                bus.wdsel    = WD_PC;
                bus.retire   = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                pcwrite    = 1'b1;
                bus.pcsrc  = PC_RS;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        bus.pcen = pcwrite | (beq & bus.zero) | (bne & ~bus.zero);
    end

    // Wait counter: restarts on every state change, counts stalled request cycles
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (bus.mem_req && !bus.mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles to wait for mem_ready per access (legal range 2..255).
REQ-002 SHALL have parameter ALUW, default 4, meaning alucontrol width; codes add=0010, sub=1010, or=0001, and=0000, slt=1011, sltu=1100.
REQ-003 SHALL have one clock and an asynchronous active-high reset, ports clk and reset; all other ports follow.
REQ-004 Inputs: op (6 bits) and funct (6 bits) from the instruction register; zero (1 bit, ALU zero); mem_ready (1 bit, memory access complete this cycle).
REQ-005 Outputs, 1 bit each: mem_req, memwrite, iord (0=PC, 1=ALUOut address), irwrite, regwrite, signext, shiftl16, alusrca (0=PC, 1=rs), pcen.
REQ-006 Outputs, 2 bits each: regdst (00 rt, 01 rd, 10 $31), wdsel (00 ALUOut, 01 MDR, 10 PC), pcsrc (00 ALU, 01 ALUOut, 10 jump target, 11 rs).
REQ-007 Other outputs: alusrcb (2 bits: 00 rt, 01 const 4, 10 ext imm, 11 imm<<2); alucontrol (ALUW bits); retire (1 bit, one-cycle pulse on instruction completion); bus_err (1 bit, sticky); illegal (1 bit, sticky).

Function
REQ-008 Multicycle Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BREX, IMMEX, IMMWB, JMP, JAL, JR, HALT.
REQ-009 Every output not listed for a state SHALL be 0; pcen = pcwrite | (beq & zero) | (bne & ~zero), evaluated combinationally.
REQ-010 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add; stay until mem_ready; on mem_ready assert irwrite=1 and pcwrite=1 in that cycle, then go to DECODE.
REQ-011 DECODE: alusrca=0, alusrcb=11, add. Next state by op: LW/SW (100011/101011) -> MEMADR; R-type (000000) -> RTEX, or JR when funct=001000; BEQ/BNE (000100/000101) -> BREX; ADDI/ADDIU/ORI/LUI (001000/001001/001101/001111) -> IMMEX; J (000010) -> JMP; JAL (000011) -> JAL; any other op -> HALT with illegal set.
REQ-012 MEMADR: alusrca=1, alusrcb=10, signext=1, add; next MEMRD for LW, MEMWR for SW.
REQ-013 MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB. MEMWB: regwrite=1, regdst=00, wdsel=01, retire=1 -> FETCH.
REQ-014 MEMWR: mem_req=1, memwrite=1, iord=1; on mem_ready retire=1 -> FETCH.
REQ-015 RTEX: alusrca=1, alusrcb=00; alucontrol from funct (100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 101010 slt, 101011 sltu, 000000 or). Unknown funct -> HALT with illegal set; else -> RTWB.
REQ-016 RTWB: regwrite=1, regdst=01, wdsel=00, retire=1 -> FETCH.
REQ-017 BREX: alusrca=1, alusrcb=00, sub, pcsrc=01; beq asserted for op 000100, bne for op 000101; retire=1 -> FETCH.
REQ-018 IMMEX: alusrca=1, alusrcb=10; ORI: or with signext=0; LUI: add with shiftl16=1 and signext=0; ADDI/ADDIU: add with signext=1; -> IMMWB. IMMWB: regwrite=1, regdst=00, wdsel=00, retire=1 -> FETCH.
REQ-019 JMP: pcwrite=1, pcsrc=10, retire=1 -> FETCH. JAL: same as JMP plus regwrite=1, regdst=10, wdsel=10; PC already holds PC+4.
REQ-020 JR: pcwrite=1, pcsrc=11, retire=1 -> FETCH.
REQ-021 Wait counter: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle mem_req=1 and mem_ready=0.
REQ-022 When the counter reaches TIMEOUT-1 with mem_ready still 0, the FSM SHALL go to HALT and set bus_err. mem_ready in that same cycle takes priority and the access completes normally.
REQ-023 HALT: all outputs 0 except the sticky flags; remain in HALT until reset.
REQ-024 mem_ready outside mem_req states SHALL be ignored.

Reset
REQ-025 Asynchronous reset SHALL force state=FETCH, clear the counter, and clear bus_err and illegal; after release, mem_req=1 combinationally.
REQ-026 Reset mid-access SHALL abandon the access; no irwrite, regwrite or pcwrite follows.

Structure
REQ-027 State encodings, ALU codes, opcode/funct constants and mux select codes SHALL live in shared package mips_pkg.
REQ-028 Single sub-module mc_aludec (funct/state -> alucontrol, illegal-funct flag); FSM and counter stay in mc_controller.

Verification
REQ-029 LW with mem_ready delayed 3 cycles in FETCH and 2 cycles in MEMRD -> 5 base states + 5 wait cycles; one retire pulse; regwrite with wdsel=01 in MEMWB.
REQ-030 BEQ with zero=1 -> pcen=1 in BREX; BNE with zero=1 -> pcen=0; both return to FETCH.
REQ-031 JAL -> regdst=10, wdsel=10, pcsrc=10, pcen=1 in one cycle; retire=1.
REQ-032 TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 cycles, bus_err=1; mem_ready asserted on the 4th cycle -> normal DECODE, no bus_err.
REQ-033 op=111111 -> HALT with illegal=1, no further mem_req; reset -> FETCH, flags cleared.
REQ-034 Reset asserted during MEMWR wait -> immediate FETCH, memwrite=0, no retire.
